// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle add/sub/and/or, bit-serial logical shifts,
// start/done handshake with registered result, zero and overflow flags.
module alu_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       operation,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             invalid,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   localparam logic [5:0] OP_ADD = 6'd27;
   localparam logic [5:0] OP_SUB = 6'd28;
   localparam logic [5:0] OP_AND = 6'd29;
   localparam logic [5:0] OP_OR  = 6'd30;
   localparam logic [5:0] OP_SRL = 6'd31;
   localparam logic [5:0] OP_SLL = 6'd32;

   logic [0:0]         state;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   acc_next;
   logic [SHAMT_W-1:0] cnt;
   logic [SHAMT_W-1:0] shamt;
   logic               dir_left;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic               add_ovf;
   logic               sub_ovf;

   always_comb begin
      sum      = src1 + src2;
      diff     = src1 - src2;
      add_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
      sub_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
      shamt    = src2[SHAMT_W-1:0];
      acc_next = dir_left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
   end

   assign busy = (state == S_SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         result   <= '0;
         zero     <= 1'b1;
         overflow <= 1'b0;
         invalid  <= 1'b0;
         done     <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         dir_left <= 1'b0;
      end else begin
         done    <= 1'b0;
         invalid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (operation)
                     OP_ADD: begin
                        result   <= sum;
                        zero     <= (sum == '0);
                        overflow <= add_ovf;
                        done     <= 1'b1;
                     end
                     OP_SUB: begin
                        result   <= diff;
                        zero     <= (diff == '0);
                        overflow <= sub_ovf;
                        done     <= 1'b1;
                     end
                     OP_AND: begin
                        result   <= src1 & src2;
                        zero     <= ((src1 & src2) == '0);
                        overflow <= 1'b0;
                        done     <= 1'b1;
                     end
                     OP_OR: begin
                        result   <= src1 | src2;
                        zero     <= ((src1 | src2) == '0);
                        overflow <= 1'b0;
                        done     <= 1'b1;
                     end
                     OP_SRL, OP_SLL: begin
                        // A zero shift amount completes immediately like the 1-cycle ops
                        if (shamt == '0) begin
                           result   <= src1;
                           zero     <= (src1 == '0);
                           overflow <= 1'b0;
                           done     <= 1'b1;
                        end else begin
                           acc      <= src1;
                           cnt      <= shamt;
                           dir_left <= (operation == OP_SLL);
                           state    <= S_SHIFT;
                        end
                     end
                     default: begin
                        result   <= '0;
                        zero     <= 1'b1;
                        overflow <= 1'b0;
                        invalid  <= 1'b1;
                        done     <= 1'b1;
                     end
                  endcase
               end
            end
            S_SHIFT: begin
               acc <= acc_next;
               cnt <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  result   <= acc_next;
                  zero     <= (acc_next == '0);
                  overflow <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  operation = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        invalid;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;

   alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .operation(operation),
      .src1(src1), .src2(src2), .result(result), .zero(zero),
      .overflow(overflow), .invalid(invalid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference: results from plain arithmetic; overflow from the true signed
   // value falling outside the 32-bit range. lat = negedges from the start
   // edge until done is seen (1 for single-cycle ops, shamt+1 for shifts).
   function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ov, output logic inv,
                                 output int lat);
      longint s;
      int sh;
      sh  = int'(b % 32);
      r   = '0;
      ov  = 1'b0;
      inv = 1'b0;
      lat = 1;
      case (op)
         6'd27: begin
            s  = longint'($signed(a)) + longint'($signed(b));
            r  = a + b;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         6'd28: begin
            s  = longint'($signed(a)) - longint'($signed(b));
            r  = a - b;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         6'd29: r = a & b;
         6'd30: r = a | b;
         6'd31: begin r = a / (32'd1 << sh); lat = (sh == 0) ? 1 : sh + 1; end
         6'd32: begin r = a * (32'd1 << sh); lat = (sh == 0) ? 1 : sh + 1; end
         default: inv = 1'b1;
      endcase
   endfunction

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int wait_cyc, output int busy_cyc, output int overlap);
      @(negedge clk);
      operation = op; src1 = a; src2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc = 1; busy_cyc = 0; overlap = 0;
      while (!done && wait_cyc < 200) begin
         if (busy) busy_cyc++;
         @(negedge clk);
         wait_cyc++;
      end
      if (busy && done) overlap = 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests++;
      if ({result, zero, overflow, invalid, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: got res=%h z=%b ov=%b inv=%b busy=%b done=%b, want res=0 z=1 ov=0 inv=0 busy=0 done=0",
                  result, zero, overflow, invalid, busy, done);
      end
   endtask

   task automatic test_add();
      int w, bc, ovl;
      issue(6'd27, 32'h7FFFFFFF, 32'h1, w, bc, ovl);
      tests++;
      if (w !== 1) begin fails++; $display("FAIL add_latency: got %0d want 1", w); end
      tests++;
      if ({result, overflow, zero, invalid} !== {32'h80000000, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL add_ovf: got res=%h ov=%b z=%b inv=%b want res=80000000 ov=1 z=0 inv=0", result, overflow, zero, invalid);
      end
      @(negedge clk);
      tests++;
      if ({done, result} !== {1'b0, 32'h80000000}) begin
         fails++;
         $display("FAIL done_pulse_hold: got done=%b res=%h want done=0 res=80000000", done, result);
      end
   endtask

   task automatic test_sub();
      int w, bc, ovl;
      issue(6'd28, 32'h12345678, 32'h12345678, w, bc, ovl);
      tests++;
      if ({w, result, zero, overflow} !== {32'd1, 32'h0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL sub_zero: got lat=%0d res=%h z=%b ov=%b want lat=1 res=0 z=1 ov=0", w, result, zero, overflow);
      end
      issue(6'd28, 32'h80000000, 32'h1, w, bc, ovl);
      tests++;
      if ({result, overflow, zero} !== {32'h7FFFFFFF, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL sub_ovf: got res=%h ov=%b z=%b want res=7fffffff ov=1 z=0", result, overflow, zero);
      end
   endtask

   task automatic test_shift();
      int w, bc, ovl;
      issue(6'd32, 32'h1, 32'd5, w, bc, ovl);
      tests++;
      if ({w, bc, ovl, result} !== {32'd6, 32'd5, 32'd0, 32'h20}) begin
         fails++;
         $display("FAIL sll5: got lat=%0d busy=%0d ovl=%0d res=%h want lat=6 busy=5 ovl=0 res=20", w, bc, ovl, result);
      end
      issue(6'd31, 32'h80000000, 32'd31, w, bc, ovl);
      tests++;
      if ({w, bc, result, overflow} !== {32'd32, 32'd31, 32'h1, 1'b0}) begin
         fails++;
         $display("FAIL srl31: got lat=%0d busy=%0d res=%h ov=%b want lat=32 busy=31 res=1 ov=0", w, bc, result, overflow);
      end
      issue(6'd31, 32'hDEADBEEF, 32'hFFFFFFE0, w, bc, ovl);
      tests++;
      if ({w, bc, result} !== {32'd1, 32'd0, 32'hDEADBEEF}) begin
         fails++;
         $display("FAIL srl0: got lat=%0d busy=%0d res=%h want lat=1 busy=0 res=deadbeef", w, bc, result);
      end
   endtask

   task automatic test_busy_ignore();
      int dones;
      int invs;
      logic [31:0] seen;
      dones = 0; invs = 0; seen = '0;
      @(negedge clk);
      operation = 6'd32; src1 = 32'h3; src2 = 32'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin operation = 6'd27; src1 = 32'd100; src2 = 32'd200; start = 1'b1; end
         if (i == 4) start = 1'b0;
         if (done) begin dones++; seen = result; end
         if (invalid) invs++;
         @(negedge clk);
      end
      tests++;
      if ({dones, invs, seen} !== {32'd1, 32'd0, 32'h300}) begin
         fails++;
         $display("FAIL busy_ignore: got dones=%0d inv=%0d res=%h want dones=1 inv=0 res=300", dones, invs, seen);
      end
   endtask

   task automatic test_invalid_back_to_back();
      int w, bc, ovl;
      issue(6'd33, 32'h1234, 32'h5678, w, bc, ovl);
      tests++;
      if ({w, invalid, result, zero, overflow} !== {32'd1, 1'b1, 32'h0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL invalid_op: got lat=%0d inv=%b res=%h z=%b ov=%b want lat=1 inv=1 res=0 z=1 ov=0", w, invalid, result, zero, overflow);
      end
      @(negedge clk);
      operation = 6'd29; src1 = 32'hF0F0; src2 = 32'hFF00; start = 1'b1;
      @(negedge clk);
      operation = 6'd30; src1 = 32'hF0F0; src2 = 32'h0F0F;
      tests++;
      if ({done, invalid, result} !== {1'b1, 1'b0, 32'hF000}) begin
         fails++;
         $display("FAIL b2b_and: got done=%b inv=%b res=%h want done=1 inv=0 res=f000", done, invalid, result);
      end
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({done, result} !== {1'b1, 32'hFFFF}) begin
         fails++;
         $display("FAIL b2b_or: got done=%b res=%h want done=1 res=ffff", done, result);
      end
   endtask

   task automatic test_reset_mid_shift();
      int w, bc, ovl;
      int dones;
      dones = 0;
      @(negedge clk);
      operation = 6'd32; src1 = 32'h1; src2 = 32'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i < 10; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if ({busy, done, result, zero} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
         fails++;
         $display("FAIL mid_reset: got busy=%b done=%b res=%h z=%b want busy=0 done=0 res=0 z=1", busy, done, result, zero);
      end
      for (int i = 0; i < 25; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      tests++;
      if (dones !== 0) begin fails++; $display("FAIL mid_reset_nodone: got %0d dones want 0", dones); end
      issue(6'd27, 32'd2, 32'd3, w, bc, ovl);
      tests++;
      if ({w, result} !== {32'd1, 32'd5}) begin
         fails++;
         $display("FAIL add_after_reset: got lat=%0d res=%h want lat=1 res=5", w, result);
      end
   endtask

   task automatic test_random();
      int w, bc, ovl;
      logic [5:0]  op;
      logic [31:0] a, b, er;
      logic        eov, einv;
      int          elat;
      for (int n = 0; n < 40; n++) begin
         op = 6'(27 + $urandom_range(0, 6));
         if (n % 9 == 8) op = 6'($urandom_range(0, 63));
         a = $urandom();
         b = (n % 5 == 0) ? a : $urandom();
         if (op == 6'd27 && n % 4 == 1) b = 32'h7FFFFFFF;
         model(op, a, b, er, eov, einv, elat);
         issue(op, a, b, w, bc, ovl);
         tests++;
         if ({result, zero, overflow, invalid, w, ovl} !== {er, (er == 32'h0), eov, einv, elat, 32'd0}) begin
            fails++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: got res=%h z=%b ov=%b inv=%b lat=%0d ovl=%0d want res=%h z=%b ov=%b inv=%b lat=%0d ovl=0",
                     n, op, a, b, result, zero, overflow, invalid, w, ovl, er, (er == 32'h0), eov, einv, elat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_shift();
      test_busy_ignore();
      test_invalid_back_to_back();
      test_reset_mid_shift();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
